branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the rv32i core: a direct-mapped table of 2-bit saturating counters plus a small branch target buffer (BTB). The fetch stage queries it with the current PC and gets a direction and target in the same cycle. The execute stage writes back the resolved outcome (`branch_taken` and target from branch control), which trains the table.

## Interface
- `ENTRIES`, 64, number of counter/BTB entries; power of two, at least 4.
- `GHR_BITS`, 6, global history length; only used when gshare is enabled; must be ≤ log2(`ENTRIES`).
- `clk` in 1: core clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `pred_pc` in 32: fetch-stage PC being looked up.
- `pred_hit` out 1: a valid BTB entry's tag matches `pred_pc`.
- `pred_taken` out 1: predicted taken; equals `pred_hit & counter[1]`.
- `pred_target` out 32: BTB target when `pred_hit`, else 32'h0.
- `upd_valid` in 1: a B-type branch resolved this cycle.
- `upd_pc` in 32: PC of the resolved branch.
- `upd_taken` in 1: resolved direction (branch control's `branch_taken`).
- `upd_target` in 32: resolved branch target (PC + B-immediate).

## Operation
- Index `IW = log2(ENTRIES)`. Base index = `pc[IW+1:2]`. PC bits [1:0] are ignored.
- Tag = `pc[31:IW+2]`, width `30-IW`.
- Per-entry state:
  - 2-bit counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - BTB valid bit, tag, and 32-bit target.
- Lookup is purely combinational from `pred_pc` and the current registered state.
- Update happens on a clock edge with `upd_valid=1`:
  - Counter: taken increments and saturates at 11; not-taken decrements and saturates at 00.
  - BTB: taken writes valid=1, tag=`upd_pc` tag, target=`upd_target`, overwriting any alias. Not-taken leaves the BTB unchanged.
- With `upd_valid=0`, no state changes.
- Counter and BTB are indexed with the same index function.
- Aliasing between two branches that share an index is permitted. The counters interfere; the BTB is protected by the tag.

## Timing
- Lookup latency is 0 cycles. Update is visible to lookups the cycle after the update edge.
- A lookup and an update to the same index in the same cycle: the lookup returns the pre-update value. There is no bypass.
- Reset (asynchronous, any time, including mid-update):
  - All counters go to 01.
  - All BTB valid bits clear. Tags and targets need no reset.
  - The GHR clears.
  - Result: `pred_hit=0`, `pred_taken=0`, `pred_target=0` immediately and until the first taken update.
- An update coincident with reset deassertion is ignored if `rst` is high at the edge.
- Counter arithmetic is 2-bit unsigned with explicit saturation. No wrap from 11 to 00 or from 00 to 11.

## Configuration
- `BP_GSHARE_EN` defined:
  - A `GHR_BITS` register holds the most recent resolved directions.
  - Counter index = base index XOR zero-extended GHR. The BTB still uses the base index and tag.
  - On each `upd_valid` edge, GHR ← {GHR[GHR_BITS-2:0], `upd_taken`}.
  - Lookup and update both use the current, pre-shift GHR.
- `BP_GSHARE_EN` undefined:
  - No GHR exists; `GHR_BITS` is unused.
  - Counter index = base index (bimodal).

## Structure
- The `risc_pkg` package gets:
  - typedef `bp_ctr_t`, a 2-bit enum `BP_SNT`, `BP_WNT`, `BP_WT`, `BP_ST`;
  - constant `BP_CTR_RESET = BP_WNT`.
- One sub-module, `bp_btb`: valid/tag/target arrays, combinational hit/target read, and a write port driven on taken updates.
- Counters, GHR and index logic live in `branch_predictor`.

## Test plan
- **Reset state:** assert `rst`, then query `pred_pc=0x100` → `pred_hit=0`, `pred_taken=0`, `pred_target=0`.
- **Training:** two taken updates for pc 0x100, target 0x80. Then query 0x100 → `pred_hit=1`, `pred_taken=1`, `pred_target=0x80`. Three not-taken updates → `pred_taken=0`, `pred_hit=1`.
- **Saturation:** five taken updates then one not-taken → still taken (counter 10). A second not-taken → not taken.
- **Alias:** train 0x100 taken. With `ENTRIES=64`, `pred_pc=0x200` has the same index but a different tag → `pred_hit=0`, `pred_taken=0`. A taken update at 0x200 (target 0x40) → 0x100 now misses and 0x200 hits with target 0x40.
- **Same-cycle read/write:** `pred_pc=upd_pc=0x100` with the counter at 01 and a taken update → `pred_taken=0` this cycle, 1 the next.
- **`BP_GSHARE_EN`:** update taken/not-taken alternately at 0x100 and check the GHR shift sequence. Then verify the same pc predicts differently under GHR 0x2A versus 0x15 after training.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared rv32i core types: 2-bit branch direction counter and its saturating update.
package risc_pkg;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_ctr_t;

  localparam bp_ctr_t BP_CTR_RESET = BP_WNT;

  // Saturating step: no wrap between the two strong states.
  function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken);
    bp_ctr_t nxt;
    // NOTE: a default value before the case keeps every path assigned, so no latch is inferred.
    nxt = ctr;
    unique case (ctr)
      BP_SNT: nxt = taken ? BP_WNT : BP_SNT;
      BP_WNT: nxt = taken ? BP_WT  : BP_SNT;
      BP_WT:  nxt = taken ? BP_ST  : BP_WNT;
      BP_ST:  nxt = taken ? BP_ST  : BP_WT;
      default: nxt = BP_CTR_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side training signals of the branch predictor.
interface branch_predictor_if;
  logic [31:0] pred_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  modport master (
    output pred_pc, upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_hit, pred_taken, pred_target
  );

  modport slave (
    input  pred_pc, upd_valid, upd_pc, upd_taken, upd_target,
    output pred_hit, pred_taken, pred_target
  );
endinterface

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational tagged read, single write port.
module bp_btb #(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc,
  output logic        rd_hit,
  output logic [31:0] rd_target,
  input  logic        wr_en,
  input  logic [31:0] wr_pc,
  input  logic [31:0] wr_target
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;

  logic [ENTRIES-1:0] valid_q;
  logic [TW-1:0]      tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [IW-1:0] rd_idx, wr_idx;
  logic [TW-1:0] rd_tag, wr_tag;
  logic          unused_pc_lsbs;

  assign rd_idx = rd_pc[IW+1:2];
  assign rd_tag = rd_pc[31:IW+2];
  assign wr_idx = wr_pc[IW+1:2];
  assign wr_tag = wr_pc[31:IW+2];
  assign unused_pc_lsbs = ^{rd_pc[1:0], wr_pc[1:0]};

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_target = rd_hit ? target_q[rd_idx] : 32'h0;

  // NOTE: only the valid bits are reset; tag/target RAM stays reset-free since a cleared valid masks it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal 2-bit counter predictor with BTB; define BP_GSHARE_EN to XOR global history
// into the counter index (gshare). BTB always uses the plain PC index and tag.
module branch_predictor
  import risc_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int GHR_BITS = 6
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);

  localparam int IW = $clog2(ENTRIES);

  if (ENTRIES < 4 || (1 << IW) != ENTRIES || GHR_BITS < 2 || GHR_BITS > IW) begin : g_bad_cfg
    $error("branch_predictor: ENTRIES must be a power of two >= 4 and 2 <= GHR_BITS <= log2(ENTRIES)");
  end

  logic [IW-1:0] pred_base, upd_base;
  logic [IW-1:0] pred_ctr_idx, upd_ctr_idx;
  bp_ctr_t       ctr_q [ENTRIES];
  bp_ctr_t       pred_ctr;
  logic          btb_hit;
  logic [31:0]   btb_target;

  assign pred_base = bp.pred_pc[IW+1:2];
  assign upd_base  = bp.upd_pc[IW+1:2];

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (bp.upd_valid) begin
      ghr_q <= {ghr_q[GHR_BITS-2:0], bp.upd_taken};
    end
  end

  // Both ports hash with the pre-shift history, so training lands where the lookup looked.
  assign pred_ctr_idx = pred_base ^ IW'(ghr_q);
  assign upd_ctr_idx  = upd_base ^ IW'(ghr_q);
`else
  assign pred_ctr_idx = pred_base;
  assign upd_ctr_idx  = upd_base;
`endif

  // NOTE: sequential state uses non-blocking assignment so every read sees the pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BP_CTR_RESET;
    end else if (bp.upd_valid) begin
      ctr_q[upd_ctr_idx] <= bp_ctr_next(ctr_q[upd_ctr_idx], bp.upd_taken);
    end
  end

  bp_btb #(.ENTRIES(ENTRIES)) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc     (bp.pred_pc),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .wr_en     (bp.upd_valid && bp.upd_taken),
    .wr_pc     (bp.upd_pc),
    .wr_target (bp.upd_target)
  );

  assign pred_ctr       = ctr_q[pred_ctr_idx];
  assign bp.pred_hit    = btb_hit;
  assign bp.pred_taken  = btb_hit & pred_ctr[1];
  assign bp.pred_target = btb_target;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (ENTRIES=64); honours BP_GSHARE_EN in its reference model.
module tb_branch_predictor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if bp ();

  branch_predictor dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp)
  );

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int          m_ctr   [64];
  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  logic [5:0]  m_ghr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int m_base(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int m_cidx(input logic [31:0] pc);
`ifdef BP_GSHARE_EN
    return m_base(pc) ^ int'(m_ghr);
`else
    return m_base(pc);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_ctr[i]   = 1;
      m_valid[i] = 1'b0;
    end
    m_ghr = '0;
  endtask

  function automatic exp_t model_predict(input logic [31:0] pc, input string name);
    exp_t e;
    int   b;
    b        = m_base(pc);
    e.name   = name;
    e.hit    = m_valid[b] && (m_tag[b] == (pc >> 8));
    e.taken  = e.hit && (m_ctr[m_cidx(pc)] >= 2);
    e.target = e.hit ? m_tgt[b] : 32'h0;
    return e;
  endfunction

  task automatic model_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    int c;
    int b;
    c = m_cidx(pc);
    b = m_base(pc);
    if (taken) begin
      if (m_ctr[c] < 3) m_ctr[c]++;
      m_valid[b] = 1'b1;
      m_tag[b]   = pc >> 8;
      m_tgt[b]   = tgt;
    end else if (m_ctr[c] > 0) begin
      m_ctr[c]--;
    end
    m_ghr = {m_ghr[4:0], taken};
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check({e.name, "_hit"},    {31'd0, bp.pred_hit},   {31'd0, e.hit});
    check({e.name, "_taken"},  {31'd0, bp.pred_taken}, {31'd0, e.taken});
    check({e.name, "_target"}, bp.pred_target,         e.target);
  endtask

  // One cycle: drive lookup + optional update, compare at negedge, retire update at posedge.
  task automatic step(input logic [31:0] ppc, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utg, input string name);
    bp.pred_pc    = ppc;
    bp.upd_valid  = uv;
    bp.upd_pc     = upc;
    bp.upd_taken  = ut;
    bp.upd_target = utg;
    sb_q.push_back(model_predict(ppc, name));
    @(negedge clk);
    compare_pop();
`ifdef BP_GSHARE_EN
    check({name, "_ghr"}, {26'd0, dut.ghr_q}, {26'd0, m_ghr});
`endif
    if (uv) model_update(upc, ut, utg);
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input logic [31:0] ppc, input logic eh, input logic et,
                       input logic [31:0] etg, input string name);
    exp_t e;
`ifdef BP_GSHARE_EN
    e = model_predict(ppc, name);
`else
    e.name = name; e.hit = eh; e.taken = et; e.target = etg;
`endif
    bp.pred_pc   = ppc;
    bp.upd_valid = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    compare_pop();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bp.upd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt, input int n);
    for (int i = 0; i < n; i++) step(32'h0000_0104, 1'b1, pc, taken, tgt, "train");
  endtask

  logic [31:0] pcs [6] = '{32'h100, 32'h104, 32'h200, 32'h300, 32'h1100, 32'h40};

  initial begin
    bp.pred_pc = 32'h100; bp.upd_valid = 1'b0; bp.upd_pc = '0;
    bp.upd_taken = 1'b0;  bp.upd_target = '0;
    model_reset();
    #3;
    check("rst_hit",    {31'd0, bp.pred_hit},   32'd0);
    check("rst_taken",  {31'd0, bp.pred_taken}, 32'd0);
    check("rst_target", bp.pred_target,         32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    probe(32'h100, 1'b0, 1'b0, 32'h0, "reset_probe");

    // Same-cycle lookup and update: lookup sees the pre-update state.
    step(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, "same_cycle");
    probe(32'h100, 1'b1, 1'b1, 32'h80, "same_cycle_next");

    do_reset();
    train(32'h100, 1'b1, 32'h80, 2);
    probe(32'h100, 1'b1, 1'b1, 32'h80, "trained");
    train(32'h100, 1'b0, 32'h80, 3);
    probe(32'h100, 1'b1, 1'b0, 32'h80, "untrained");

    train(32'h100, 1'b1, 32'h80, 5);
    train(32'h100, 1'b0, 32'h80, 1);
    probe(32'h100, 1'b1, 1'b1, 32'h80, "sat_one_nt");
    train(32'h100, 1'b0, 32'h80, 1);
    probe(32'h100, 1'b1, 1'b0, 32'h80, "sat_two_nt");

    train(32'h100, 1'b1, 32'h80, 1);
    probe(32'h200, 1'b0, 1'b0, 32'h0, "alias_miss");
    train(32'h200, 1'b1, 32'h40, 1);
    probe(32'h100, 1'b0, 1'b0, 32'h0, "alias_evicted");
    probe(32'h200, 1'b1, 1'b1, 32'h40, "alias_hit");

`ifdef BP_GSHARE_EN
    do_reset();
    for (int i = 0; i < 6; i++) step(32'h100, 1'b1, 32'h100, (i % 2) == 0, 32'h80, "ghr_shift");
    check("ghr_2a", {26'd0, dut.ghr_q}, 32'h2A);
`endif

    for (int i = 0; i < 300; i++) begin
      step(pcs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), pcs[$urandom_range(0, 5)],
           1'($urandom_range(0, 1)), 32'($urandom) & 32'hFFFF_FFFC, "rand");
    end

    // Asynchronous reset mid-update, held across an edge that carries an update.
    do_reset();
    train(32'h100, 1'b1, 32'h80, 2);
    bp.pred_pc = 32'h100; bp.upd_valid = 1'b1; bp.upd_pc = 32'h100;
    bp.upd_taken = 1'b1;  bp.upd_target = 32'h80;
    rst = 1'b1;
    #1;
    check("async_rst_hit",    {31'd0, bp.pred_hit},   32'd0);
    check("async_rst_taken",  {31'd0, bp.pred_taken}, 32'd0);
    check("async_rst_target", bp.pred_target,         32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    probe(32'h100, 1'b0, 1'b0, 32'h0, "rst_edge_update_ignored");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
